// File: rtl/fpga_ram_bist.sv
// fpga_ram_bist: write/read-back BIST for one SRAM bank with mismatch count and first failing address
module fpga_ram_bist #(
    parameter int          ADDR_WIDTH    = 12,
    parameter logic [31:0] SEED          = 32'hA5A5_A5A5,
    parameter int          ERR_CNT_WIDTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     start_i,
    output logic                     mem_csn_o,
    output logic                     mem_wen_o,
    output logic [3:0]               mem_be_o,
    output logic [ADDR_WIDTH-1:0]    mem_addr_o,
    output logic [31:0]              mem_wdata_o,
    input  logic [31:0]              mem_rdata_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     pass_o,
    output logic [ERR_CNT_WIDTH-1:0] err_cnt_o,
    output logic [ADDR_WIDTH-1:0]    first_err_addr_o
);
    typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;
    state_t                   state, state_nxt;
    logic [ADDR_WIDTH-1:0]    cnt, cnt_nxt, cmp_addr, first_err;
    logic [31:0]              cmp_exp;
    logic                     cmp_vld;
    logic [ERR_CNT_WIDTH-1:0] err_cnt;
    logic                     restart, last, wr, rd;
    assign restart = start_i && (state == IDLE || state == DONE);
    assign last    = cnt == '1;
    assign wr      = state == WRITE;
    assign rd      = state == READ;
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE, DONE: begin
                state_nxt = restart ? WRITE : state;
                cnt_nxt   = '0;
            end
            WRITE: begin
                state_nxt = last ? READ : WRITE;
                cnt_nxt   = cnt + 1'b1;
            end
            READ: begin
                state_nxt = last ? DRAIN : READ;
                cnt_nxt   = cnt + 1'b1;
            end
            DRAIN:   state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= IDLE;
            cnt       <= '0;
            cmp_vld   <= 1'b0;
            cmp_addr  <= '0;
            cmp_exp   <= '0;
            err_cnt   <= '0;
            first_err <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            cmp_vld  <= rd;
            cmp_addr <= cnt;
            cmp_exp  <= SEED ^ 32'(cnt);
            if (restart) begin
                err_cnt   <= '0;
                first_err <= '0;
            end else if (cmp_vld && mem_rdata_i != cmp_exp) begin
                err_cnt   <= (err_cnt == '1) ? err_cnt : err_cnt + 1'b1;
                first_err <= (err_cnt == '0) ? cmp_addr : first_err;
            end
        end
    end
    assign mem_csn_o        = !(wr || rd);
    assign mem_wen_o        = !wr;
    assign mem_be_o         = wr ? 4'hF : 4'h0;
    assign mem_addr_o       = (wr || rd) ? cnt : '0;
    assign mem_wdata_o      = wr ? SEED ^ 32'(cnt) : 32'h0;
    assign busy_o           = wr || rd || state == DRAIN;
    assign done_o           = state == DONE;
    assign pass_o           = done_o && err_cnt == '0;
    assign err_cnt_o        = err_cnt;
    assign first_err_addr_o = first_err;
endmodule
